// File: rtl/pe_mac_if.sv
// ----------------------------------------------------------------------------
// pe_mac_if
// Handshake bundle between the PE operand feeder, the MAC pipeline and the
// result collector.
//   Operand side : in_valid, in_ready, A, B, is_signed, acc_en, acc_clr
//   Result side  : out_valid, out_ready, P, acc_ovf
// Modports:
//   master : the environment (drives operands and out_ready)
//   slave  : the MAC unit
// ----------------------------------------------------------------------------
interface pe_mac_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 48
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 is_signed;
    logic                 acc_en;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] P;
    logic                 acc_ovf;

    modport master (
        output in_valid, A, B, is_signed, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, P, acc_ovf
    );

    modport slave (
        input  in_valid, A, B, is_signed, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, P, acc_ovf
    );
endinterface

// File: rtl/pe_mac_pipe.sv
// ----------------------------------------------------------------------------
// pe_mac_pipe
// Pipelined signed/unsigned multiply-accumulate unit for the NPU PE.
// Stage 0 registers the operands and sideband on acceptance, stage 1 forms two
// partial products, later stages sum them, and the output register holds
// P together with the accumulator.  A transaction accepted at edge n shows
// out_valid after edge n+STAGES.  Any output stall freezes the whole pipe.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   mac   : pe_mac_if.slave (operand/result handshakes, P, acc_ovf)
// ----------------------------------------------------------------------------
module pe_mac_pipe #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 48,
    parameter int STAGES    = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    pe_mac_if.slave  mac
);
    localparam int PW = 2 * WIDTH;

    if (WIDTH < 2) begin : g_bad_width
        $error("pe_mac_pipe: WIDTH must be >= 2");
    end
    if (ACC_WIDTH < PW) begin : g_bad_acc
        $error("pe_mac_pipe: ACC_WIDTH must be >= 2*WIDTH");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("pe_mac_pipe: STAGES must be in 1..4");
    end

    typedef logic [ACC_WIDTH-1:0] acc_t;

    typedef struct packed {
        logic             sgn;
        logic             acc_en;
        logic             acc_clr;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [PW-1:0]    pp_lo;
        logic [PW-1:0]    pp_hi;
    } stage_t;

    // Both operands are widened to 2*WIDTH; the product modulo 2^(2*WIDTH)
    // then equals the exact signed or unsigned result.  B is split in halves
    // so the product is a_x*b_lo + (a_x*b_hi << WIDTH).
    function automatic stage_t pp_gen(input stage_t s);
        stage_t        r;
        logic [PW-1:0] a_x;
        logic [PW-1:0] b_x;
        r     = s;
        a_x   = {{WIDTH{s.sgn & s.a[WIDTH-1]}}, s.a};
        b_x   = {{WIDTH{s.sgn & s.b[WIDTH-1]}}, s.b};
        r.pp_lo = a_x * {{WIDTH{1'b0}}, b_x[WIDTH-1:0]};
        r.pp_hi = (a_x * {{WIDTH{1'b0}}, b_x[PW-1:WIDTH]}) << WIDTH;
        return r;
    endfunction

    // Later stages fold the partial products; pp_hi becomes zero so the
    // final stage can always add both fields.
    function automatic stage_t pp_reduce(input stage_t s);
        stage_t r;
        r       = s;
        r.pp_lo = s.pp_lo + s.pp_hi;
        r.pp_hi = '0;
        return r;
    endfunction

    stage_t          stg_q [STAGES];
    stage_t          stg_d [STAGES];
    logic [STAGES:0] vld_pipe_q;
    acc_t            acc_q, acc_d;
    acc_t            p_q, p_d;
    logic            ovf_q, ovf_d;
    logic            stall;

    assign stall         = vld_pipe_q[STAGES] & ~mac.out_ready;
    assign mac.in_ready  = ~stall;
    assign mac.out_valid = vld_pipe_q[STAGES];
    assign mac.P         = p_q;
    assign mac.acc_ovf   = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_in
            assign stg_d[k] = '{sgn:     mac.is_signed,
                                acc_en:  mac.acc_en,
                                acc_clr: mac.acc_clr,
                                a:       mac.A,
                                b:       mac.B,
                                pp_lo:   '0,
                                pp_hi:   '0};
        end else if (k == 1) begin : g_pp
            assign stg_d[k] = pp_gen(stg_q[k-1]);
        end else begin : g_red
            assign stg_d[k] = pp_reduce(stg_q[k-1]);
        end
    end

    // Output stage: product sign/zero extension, accumulate and overflow.
    stage_t           fin;
    logic [PW-1:0]    prod;
    acc_t             ext;
    logic [ACC_WIDTH:0] sum;
    logic             ovf_new;

    always_comb begin
        fin     = (STAGES == 1) ? pp_gen(stg_q[0]) : stg_q[STAGES-1];
        prod    = fin.pp_lo + fin.pp_hi;
        ext     = acc_t'(prod);
        if (fin.sgn && prod[PW-1]) begin
            ext = ext | ~acc_t'({PW{1'b1}});
        end
        sum     = {1'b0, acc_q} + {1'b0, ext};
        ovf_new = fin.sgn ? ((acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                             (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                          : sum[ACC_WIDTH];
        acc_d   = acc_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        if (vld_pipe_q[STAGES-1]) begin
            p_d = ext;
            if (fin.acc_en) begin
                if (fin.acc_clr) begin
                    acc_d = ext;
                    ovf_d = 1'b0;
                end else begin
                    acc_d = sum[ACC_WIDTH-1:0];
                    p_d   = sum[ACC_WIDTH-1:0];
                    ovf_d = ovf_q | ovf_new;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            acc_q      <= '0;
            p_q        <= '0;
            ovf_q      <= 1'b0;
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
        end else if (!stall) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], mac.in_valid};
            acc_q      <= acc_d;
            p_q        <= p_d;
            ovf_q      <= ovf_d;
            for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
        end
    end
endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed-vector bench for pe_mac_pipe (WIDTH=8, ACC_WIDTH=24, STAGES=3).
// The driver pushes hand-computed expected results into a queue on
// acceptance; an independent monitor pops and compares on every output
// transfer and also watches stall behaviour.
module tb_pe_mac_pipe;
    localparam int W  = 8;
    localparam int AW = 24;
    localparam int ST = 3;

    typedef struct {
        logic [AW-1:0] p;
        logic          ovf;
        bit            lat;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    pe_mac_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

    pe_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .STAGES(ST)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mac   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                        input bit en, input bit clr, input logic [AW-1:0] ep,
                        input bit eovf, input bit lat);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.is_signed = sgn; bus.acc_en = en; bus.acc_clr = clr;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", guard);
            bus.in_valid = 1'b0;
            return;
        end
        e.p = ep; e.ovf = eovf; e.lat = lat; e.cyc = cyc + 1 + ST;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        idle();
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk); guard++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Signed -128*-128 accumulated 512 times: the 512th sum is 2^23 and
    // flips the sign bit, so only it (and anything later) reports overflow.
    task automatic ovf_run();
        send(8'h80, 8'h80, 1, 1, 1, 24'd16384, 0, 0);
        for (int k = 2; k <= 512; k++)
            send(8'h80, 8'h80, 1, 1, 0, AW'(16384 * k), k >= 512, 0);
    endtask

    // Monitor: decoupled from stimulus; samples well after the falling edge.
    logic [AW-1:0] held_p;
    bit            stall_prev = 0;
    always begin
        exp_t e;
        @(negedge clk); #2;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (!bus.out_ready) begin
                chk("in_ready_in_stall", {31'b0, bus.in_ready}, 32'd0);
                if (stall_prev) chk("p_held_in_stall", {8'b0, bus.P}, {8'b0, held_p});
                held_p     = bus.P;
                stall_prev = 1;
            end else begin
                stall_prev = 0;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: P=%h with empty scoreboard", bus.P);
                end else begin
                    e = sb.pop_front();
                    chk("P", {8'b0, bus.P}, {8'b0, e.p});
                    chk("acc_ovf", {31'b0, bus.acc_ovf}, {31'b0, e.ovf});
                    if (e.lat) chk("latency_cycle", cyc, e.cyc);
                end
            end
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.A = '0; bus.B = '0; bus.is_signed = 1'b0; bus.acc_en = 1'b0; bus.acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_P", {8'b0, bus.P}, 32'd0);
        chk("rst_acc_ovf", {31'b0, bus.acc_ovf}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // 1: products, latency 3
        send(8'hFF, 8'hFF, 0, 0, 0, 24'h00FE01, 0, 1);
        send(8'h80, 8'h80, 1, 0, 0, 24'h004000, 0, 1);
        send(8'hFF, 8'h7F, 1, 0, 0, 24'hFFFF81, 0, 1);
        drain();

        // 2: back-to-back accumulate
        send(8'd3,  8'd4,  1, 1, 1, 24'd12,  0, 1);
        send(8'hFB, 8'd2,  1, 1, 0, 24'd2,   0, 1);
        send(8'd7,  8'd7,  1, 1, 0, 24'd51,  0, 1);
        send(8'd10, 8'd10, 1, 0, 0, 24'd100, 0, 1);
        send(8'd0,  8'd0,  1, 1, 0, 24'd51,  0, 1);
        drain();

        // 3: backpressure mid-stream
        fork
            for (int i = 1; i <= 6; i++)
                send(W'(i), W'(i), 0, 0, 0, AW'(i * i), 0, 0);
            begin
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // 4: overflow, sticky, cleared by clr
        ovf_run();
        send(8'h80, 8'h80, 1, 1, 0, 24'h804000, 1, 0);
        send(8'd1,  8'd1,  1, 1, 1, 24'd1,      0, 0);
        drain();

        // 5: reset with work in flight and acc_ovf set
        ovf_run();
        drain();
        send(8'd5, 8'd5, 0, 1, 1, 24'd25, 0, 0);
        send(8'd6, 8'd6, 0, 1, 0, 24'd61, 0, 0);
        send(8'd7, 8'd7, 0, 1, 0, 24'd110, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_P", {8'b0, bus.P}, 32'd0);
        chk("midrst_acc_ovf", {31'b0, bus.acc_ovf}, 32'd0);
        repeat (10) @(negedge clk);
        send(8'd2, 8'd3, 1, 1, 0, 24'd6, 0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
